// File: rtl/nn_mac_engine_pkg.sv
// Shared types and constants for the neuron multiply-accumulate engine.
package nn_mac_engine_pkg;

  localparam int NIN_W   = 10;
  localparam int SHIFT_W = 5;
  localparam int OLOC_W  = 17;
  localparam int BIAS_W  = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_POST  = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  localparam logic [1:0] MODE_WRAP    = 2'd0;
  localparam logic [1:0] MODE_SAT     = 2'd1;
  localparam logic [1:0] MODE_RELU    = 2'd2;
  localparam logic [1:0] MODE_SAT_ALT = 2'd3;

  typedef struct packed {
    logic [NIN_W-1:0]          ninputs;
    logic [SHIFT_W-1:0]        shift;
    logic [1:0]                mode;
    logic signed [BIAS_W-1:0]  bias;
    logic [OLOC_W-1:0]         oloc;
  } cmd_t;

endpackage

// File: rtl/nn_mac_lanes.sv
// Combinational LANES-wide signed multiply with per-lane masking and an adder tree.
module nn_mac_lanes #(
  parameter int LANES = 8,
  parameter int IW    = 24,
  parameter int WW    = 16,
  parameter int ACCW  = 48,
  parameter int CNT_W = 10
) (
  input  logic [LANES*IW-1:0]    in_vec,
  input  logic [LANES*WW-1:0]    w_vec,
  input  logic [CNT_W-1:0]       active,
  output logic signed [ACCW-1:0] sum
);

  logic signed [ACCW-1:0] term_s [LANES];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [IW+WW-1:0] x_s;
    logic signed [IW+WW-1:0] w_s;
    logic signed [IW+WW-1:0] prod_s;
    assign x_s    = {{WW{in_vec[g*IW+IW-1]}}, in_vec[g*IW +: IW]};
    assign w_s    = {{IW{w_vec[g*WW+WW-1]}}, w_vec[g*WW +: WW]};
    assign prod_s = x_s * w_s;
    // Lanes at or beyond the remaining count contribute nothing, whatever their operands.
    assign term_s[g] = (CNT_W'(g) < active) ?
                       {{(ACCW-IW-WW){prod_s[IW+WW-1]}}, prod_s} : {ACCW{1'b0}};
  end

  // Sum all lane terms.
  always_comb begin
    sum = {ACCW{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      sum = sum + term_s[i];
    end
  end

endmodule

// File: rtl/nn_mac_engine.sv
// Neuron MAC engine: bias preload, beat-wise dot product, shift, output mode, result handshake.
module nn_mac_engine
  import nn_mac_engine_pkg::*;
#(
  parameter int LANES = 8,
  parameter int IW    = 24,
  parameter int WW    = 16,
  parameter int ACCW  = 48,
  parameter int OW    = 24
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [NIN_W-1:0]          cmd_ninputs,
  input  logic [SHIFT_W-1:0]        cmd_shift,
  input  logic [1:0]                cmd_mode,
  input  logic signed [IW-1:0]      cmd_bias,
  input  logic [OLOC_W-1:0]         cmd_oloc,
  input  logic                      beat_valid,
  output logic                      beat_ready,
  input  logic [LANES*IW-1:0]       beat_in,
  input  logic [LANES*WW-1:0]       beat_w,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic signed [OW-1:0]      res_data,
  output logic [OLOC_W-1:0]         res_oloc,
  output logic                      res_ovf,
  output logic                      busy
);

  localparam logic signed [ACCW-1:0] RES_MAX = {{(ACCW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] RES_MIN = {{(ACCW-OW+1){1'b1}}, {(OW-1){1'b0}}};
  localparam logic [NIN_W-1:0]       LANES_N = NIN_W'(LANES);

  state_e                  state_r;
  cmd_t                    cmd_s;
  logic [NIN_W-1:0]        remaining_r;
  logic [SHIFT_W-1:0]      shift_r;
  logic [1:0]              mode_r;
  logic [OLOC_W-1:0]       oloc_r;
  logic signed [ACCW-1:0]  acc_r, sum_r, lane_sum_s, post_t_s, post_c_s;
  logic                    sum_vld_r, cmd_ready_r, beat_ready_r, res_valid_r, res_ovf_r, busy_r;
  logic signed [OW-1:0]    res_data_r, post_data_s;
  logic [OLOC_W-1:0]       res_oloc_r;
  logic                    post_ovf_s;

  assign cmd_s = '{ninputs: cmd_ninputs, shift: cmd_shift, mode: cmd_mode,
                   bias: cmd_bias, oloc: cmd_oloc};

  nn_mac_lanes #(
    .LANES(LANES), .IW(IW), .WW(WW), .ACCW(ACCW), .CNT_W(NIN_W)
  ) u_lanes (
    .in_vec (beat_in),
    .w_vec  (beat_w),
    .active (remaining_r),
    .sum    (lane_sum_s)
  );

  // Rescale the final accumulator and apply the output mode.
  always_comb begin
    post_t_s    = acc_r >>> shift_r;
    post_c_s    = post_t_s;
    post_data_s = post_t_s[OW-1:0];
    post_ovf_s  = 1'b0;
    case (mode_r)
      MODE_WRAP: begin
        post_data_s = post_t_s[OW-1:0];
        post_ovf_s  = 1'b0;
      end
      MODE_SAT, MODE_RELU, MODE_SAT_ALT: begin
        if ((mode_r == MODE_RELU) && post_t_s[ACCW-1]) begin
          post_c_s = {ACCW{1'b0}};
        end else begin
          post_c_s = post_t_s;
        end
        if (post_c_s > RES_MAX) begin
          post_data_s = RES_MAX[OW-1:0];
          post_ovf_s  = 1'b1;
        end else if (post_c_s < RES_MIN) begin
          post_data_s = RES_MIN[OW-1:0];
          post_ovf_s  = 1'b1;
        end else begin
          post_data_s = post_c_s[OW-1:0];
          post_ovf_s  = 1'b0;
        end
      end
      default: begin
        post_data_s = post_t_s[OW-1:0];
        post_ovf_s  = 1'b0;
      end
    endcase
  end

  // Control FSM with registered handshake outputs; the lane sum is registered and
  // folded into the accumulator one cycle later, so ACCUM drains once before POST.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      remaining_r  <= {NIN_W{1'b0}};
      shift_r      <= {SHIFT_W{1'b0}};
      mode_r       <= 2'd0;
      oloc_r       <= {OLOC_W{1'b0}};
      acc_r        <= {ACCW{1'b0}};
      sum_r        <= {ACCW{1'b0}};
      sum_vld_r    <= 1'b0;
      cmd_ready_r  <= 1'b0;
      beat_ready_r <= 1'b0;
      res_valid_r  <= 1'b0;
      res_data_r   <= {OW{1'b0}};
      res_oloc_r   <= {OLOC_W{1'b0}};
      res_ovf_r    <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready_r) begin
            shift_r     <= cmd_s.shift;
            mode_r      <= cmd_s.mode;
            oloc_r      <= cmd_s.oloc;
            acc_r       <= {{(ACCW-BIAS_W){cmd_s.bias[BIAS_W-1]}}, cmd_s.bias};
            remaining_r <= cmd_s.ninputs;
            sum_vld_r   <= 1'b0;
            cmd_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            if (cmd_s.ninputs == {NIN_W{1'b0}}) begin
              state_r      <= ST_POST;
              beat_ready_r <= 1'b0;
            end else begin
              state_r      <= ST_ACCUM;
              beat_ready_r <= 1'b1;
            end
          end else begin
            cmd_ready_r <= 1'b1;
          end
        end
        ST_ACCUM: begin
          acc_r <= acc_r + (sum_vld_r ? sum_r : {ACCW{1'b0}});
          if (beat_valid && beat_ready_r) begin
            sum_r        <= lane_sum_s;
            sum_vld_r    <= 1'b1;
            remaining_r  <= (remaining_r > LANES_N) ? (remaining_r - LANES_N) : {NIN_W{1'b0}};
            beat_ready_r <= (remaining_r > LANES_N);
          end else begin
            sum_vld_r <= 1'b0;
            if (remaining_r == {NIN_W{1'b0}}) begin
              state_r <= ST_POST;
            end else begin
              state_r <= ST_ACCUM;
            end
          end
        end
        ST_POST: begin
          res_data_r  <= post_data_s;
          res_ovf_r   <= post_ovf_s;
          res_oloc_r  <= oloc_r;
          res_valid_r <= 1'b1;
          state_r     <= ST_OUT;
        end
        ST_OUT: begin
          if (res_ready) begin
            res_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            cmd_ready_r <= 1'b1;
            state_r     <= ST_IDLE;
          end else begin
            state_r <= ST_OUT;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          beat_ready_r <= 1'b0;
          res_valid_r  <= 1'b0;
          busy_r       <= 1'b0;
          cmd_ready_r  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_r;
  assign beat_ready = beat_ready_r;
  assign res_valid  = res_valid_r;
  assign res_data   = res_data_r;
  assign res_oloc   = res_oloc_r;
  assign res_ovf    = res_ovf_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_nn_mac_engine.sv
// Bench for nn_mac_engine: directed vector table, reset corner case, randomized neurons vs. reference model.
module tb_nn_mac_engine;

  localparam int LANES = 8;
  localparam int IW    = 24;
  localparam int WW    = 16;
  localparam int ACCW  = 48;
  localparam int OW    = 24;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 cmd_valid, cmd_ready;
  logic [9:0]           cmd_ninputs;
  logic [4:0]           cmd_shift;
  logic [1:0]           cmd_mode;
  logic [IW-1:0]        cmd_bias;
  logic [16:0]          cmd_oloc;
  logic                 beat_valid, beat_ready;
  logic [LANES*IW-1:0]  beat_in;
  logic [LANES*WW-1:0]  beat_w;
  logic                 res_valid, res_ready;
  logic [OW-1:0]        res_data;
  logic [16:0]          res_oloc;
  logic                 res_ovf, busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int in_q [1040];
  int w_q  [1040];

  nn_mac_engine #(.LANES(LANES), .IW(IW), .WW(WW), .ACCW(ACCW), .OW(OW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ninputs(cmd_ninputs),
    .cmd_shift(cmd_shift), .cmd_mode(cmd_mode), .cmd_bias(cmd_bias), .cmd_oloc(cmd_oloc),
    .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_in(beat_in), .beat_w(beat_w),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_oloc(res_oloc), .res_ovf(res_ovf), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int n; int shift; int mode; int bias;
    int ib; int is; int wb; int ws; int pad; int hold;
    longint exp_d; bit exp_o;
  } vec_t;

  task automatic check(input string nm, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out waiting on DUT", nm);
  endtask

  // Reference: plain integer dot product, floor shift, then the output mode rules.
  function automatic void model(input int n, input int shift, input int mode, input int bias,
                                output longint d, output bit o);
    longint acc, t, hi, lo_lim;
    logic signed [OW-1:0] lo;
    hi = (longint'(1) <<< (OW-1)) - 1;
    lo_lim = -(longint'(1) <<< (OW-1));
    acc = bias;
    for (int k = 0; k < n; k++) acc += longint'(in_q[k]) * longint'(w_q[k]);
    t = acc >>> shift;
    o = 1'b0;
    if (mode == 0) begin
      lo = t[OW-1:0];
      d  = lo;
    end else begin
      if (mode == 2 && t < 0) t = 0;
      if (t > hi)          begin d = hi;     o = 1'b1; end
      else if (t < lo_lim) begin d = lo_lim; o = 1'b1; end
      else                 d = t;
    end
  endfunction

  task automatic drive_beat(input int k, input int n, input int pad);
    for (int l = 0; l < LANES; l++) begin
      int idx;
      idx = k * LANES + l;
      beat_in[l*IW +: IW] = IW'((idx < n) ? in_q[idx] : pad);
      beat_w[l*WW +: WW]  = WW'((idx < n) ? w_q[idx] : pad);
    end
  endtask

  task automatic send_cmd(input int n, input int shift, input int mode, input int bias,
                          input int oloc, output bit ok);
    int t;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_ninputs = 10'(n); cmd_shift = 5'(shift);
    cmd_mode = 2'(mode); cmd_bias = IW'(bias); cmd_oloc = 17'(oloc);
    t = 0;
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    ok = cmd_ready;
    if (!ok) fail("cmd_accept");
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run(input string nm, input int n, input int shift, input int mode, input int bias,
                     input int pad, input int hold, input bit gaps,
                     input longint exp_d, input bit exp_o);
    int oloc, t, nb, acc_cnt, last;
    bit ok, stable;
    logic [OW-1:0] d0;
    logic [16:0]   l0;
    logic          o0;
    oloc = int'($urandom_range(0, 131071));
    nb = (n + LANES - 1) / LANES;
    send_cmd(n, shift, mode, bias, oloc, ok);
    if (!ok) return;
    check({nm, "_busy"}, busy, 1);
    acc_cnt = 0; last = -1; t = 0;
    drive_beat(0, n, pad);
    beat_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
    while (!res_valid && t < nb * 4 + 40) begin
      if (beat_valid && beat_ready) begin
        acc_cnt++;
        if (acc_cnt == nb) last = cyc + 1;
      end
      @(negedge clk); t++;
      drive_beat(acc_cnt, n, pad);
      beat_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
    beat_valid = 1'b0;
    if (!res_valid) begin fail({nm, "_result"}); return; end
    check({nm, "_beats"}, acc_cnt, nb);
    if (n > 0) check({nm, "_latency"}, cyc - last, 2);
    check({nm, "_data"}, $signed(res_data), exp_d);
    check({nm, "_oloc"}, res_oloc, oloc);
    check({nm, "_ovf"}, res_ovf, exp_o);
    d0 = res_data; l0 = res_oloc; o0 = res_ovf;
    stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_data !== d0 || res_oloc !== l0 || res_ovf !== o0 ||
          cmd_ready !== 1'b0 || beat_ready !== 1'b0 || busy !== 1'b1) stable = 1'b0;
    end
    if (hold > 0) check({nm, "_hold_stable"}, stable, 1);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({nm, "_after_hs"}, {cmd_ready, res_valid, busy}, 3'b100);
  endtask

  vec_t tv [13];

  initial begin
    longint ed;
    bit eo, ok;
    int n, sh, md, bs, mag;

    tv[0]  = '{3, 0, 1, 0, 1, 1, 4, 1, 8388607, 0, 32, 1'b0};
    tv[1]  = '{16, 4, 1, 0, 1000, 0, 1000, 0, 0, 5, 1000000, 1'b0};
    tv[2]  = '{8, 0, 1, 0, 8388607, 0, 32767, 0, 0, 0, 8388607, 1'b1};
    tv[3]  = '{8, 0, 0, 0, 8388607, 0, 32767, 0, 0, 0, -262136, 1'b0};
    tv[4]  = '{1, 0, 2, 0, -5, 0, 3, 0, 8388607, 0, 0, 1'b0};
    tv[5]  = '{1, 0, 1, 0, -5, 0, 3, 0, 8388607, 0, -15, 1'b0};
    tv[6]  = '{0, 0, 1, -7, 0, 0, 0, 0, 0, 0, -7, 1'b0};
    tv[7]  = '{8, 0, 3, 0, 8388607, 0, 32767, 0, 0, 0, 8388607, 1'b1};
    tv[8]  = '{8, 0, 2, 0, -8388608, 0, 32767, 0, 0, 0, 0, 1'b0};
    tv[9]  = '{8, 0, 1, 0, -8388608, 0, 32767, 0, 0, 0, -8388608, 1'b1};
    tv[10] = '{0, 1, 1, -3, 0, 0, 0, 0, 0, 0, -2, 1'b0};
    tv[11] = '{1023, 0, 1, 0, 1, 0, 1, 0, -1, 2, 1023, 1'b0};
    tv[12] = '{9, 2, 0, 100, -3, 1, 7, -2, 8388607, 0, -8, 1'b0};

    reset = 1'b0; cmd_valid = 1'b0; beat_valid = 1'b0; res_ready = 1'b0;
    cmd_ninputs = '0; cmd_shift = '0; cmd_mode = '0; cmd_bias = '0; cmd_oloc = '0;
    beat_in = '0; beat_w = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {cmd_ready, beat_ready, res_valid, res_data, res_oloc, res_ovf, busy}, 0);
    reset = 1'b1;
    @(negedge clk);
    check("cmd_ready_after_reset", {cmd_ready, busy}, 2'b10);

    for (int i = 0; i < 13; i++) begin
      for (int k = 0; k < tv[i].n; k++) begin
        in_q[k] = tv[i].ib + k * tv[i].is;
        w_q[k]  = tv[i].wb + k * tv[i].ws;
      end
      run($sformatf("vec%0d", i), tv[i].n, tv[i].shift, tv[i].mode, tv[i].bias,
          tv[i].pad, tv[i].hold, 1'b0, tv[i].exp_d, tv[i].exp_o);
    end

    // Reset after the first of two beats: everything clears, no stale result appears.
    for (int k = 0; k < 16; k++) begin in_q[k] = k + 1; w_q[k] = 2; end
    send_cmd(16, 0, 1, 5, 1234, ok);
    if (ok) begin
      drive_beat(0, 16, 0);
      beat_valid = 1'b1;
      begin
        int t;
        t = 0;
        while (!beat_ready && t < 20) begin @(negedge clk); t++; end
      end
      @(negedge clk);
      beat_valid = 1'b0;
      reset = 1'b0;
      #1;
      check("midop_reset_outputs",
            {cmd_ready, beat_ready, res_valid, res_data, res_oloc, res_ovf, busy}, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      begin
        bit quiet;
        quiet = 1'b1;
        repeat (4) begin
          @(negedge clk);
          if (res_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) quiet = 1'b0;
        end
        check("post_reset_idle", quiet, 1);
      end
      run("after_reset", 16, 0, 1, 5, 0, 0, 1'b0, 277, 1'b0);
    end

    // Randomized neurons against the reference model.
    for (int r = 0; r < 25; r++) begin
      n   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 40));
      sh  = int'($urandom_range(0, 31));
      md  = int'($urandom_range(0, 3));
      mag = int'($urandom_range(0, 16));
      bs  = int'($urandom) >>> (8 + mag);
      for (int k = 0; k < n; k++) begin
        in_q[k] = int'($urandom) >>> (8 + mag);
        w_q[k]  = int'($urandom) >>> 16;
      end
      model(n, sh, md, bs, ed, eo);
      run($sformatf("rand%0d", r), n, sh, md, bs, int'($urandom),
          int'($urandom_range(0, 3)), 1'b1, ed, eo);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
